decode_issue: RTL
=================

Name: decode_issue

Overview:
- Decode/operand-fetch stage directly upstream of the RV32IM ALU.
- Accepts fetched instructions over a valid/ready handshake and decodes OP (0110011) and OP-IMM (0010011).
- Reads the internal 32x32 register file and presents registered funct3/funct7/operands to the ALU.
- A per-register scoreboard stalls issue on RAW/WAW hazards until the writeback stage returns the result.

Parameters:
XLEN, 32, operand/register width
WB_BYPASS, 1, 1 = same-cycle writeback data forwarded into operand read; 0 = no forwarding

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  instruction valid
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  32  instruction word
ex_valid  out  1  issued op valid to ALU
ex_ready  in  1  ALU side accepts issued op
ex_funct3  out  3  ALU funct3
ex_funct7  out  7  ALU funct7
ex_op_a  out  XLEN  rs1 value
ex_op_b  out  XLEN  rs2 value or sign-extended immediate/shamt
ex_rd  out  5  destination register
ex_illegal  out  1  unsupported opcode/encoding
wb_en  in  1  writeback strobe
wb_addr  in  5  writeback register
wb_data  in  XLEN  writeback value

Behaviour:
- One clock domain on clk. Reset is synchronous and active-high on rst.
- Reset (rst=1 at a clk edge):
  - ex_valid=0, ex_funct3=0, ex_funct7=0, ex_op_a=0, ex_op_b=0, ex_rd=0, ex_illegal=0.
  - All scoreboard bits cleared.
  - Register file contents are not reset; x0 always reads 0.
  - Reset mid-stall drops the held instruction and any issued op; in_ready is 0 while rst=1.
- Output register: one entry. Accept when in_valid && in_ready. in_ready = (!ex_valid || ex_ready) && !hazard && !rst.
- Latency: accepted instruction appears on ex_* the next cycle. Held stable while ex_valid && !ex_ready.
- ex_valid clears on ex_ready with no new accept.
- Decode rules:
  - OP:
    - funct3/funct7 passed through; op_b = RF[rs2].
    - Legal funct7: 0x00, 0x20 (funct3 0 or 5 only), 0x01.
    - Anything else gives ex_illegal.
  - OP-IMM:
    - op_b = sign-extended imm[31:20]; funct7 output = 0x00.
    - funct3=1 (SLLI): op_b = zero-extended shamt[24:20]; funct7 must be 0x00.
    - funct3=5: op_b = zero-extended shamt; funct7 must be 0x00 (SRLI) or 0x20 (SRAI), passed through; else illegal.
  - Other opcodes: ex_illegal=1, ex_funct3=0, ex_funct7=0, operands 0.
    - Still consumes one handshake; no scoreboard update; no hazard check.
- Register file:
  - Written when wb_en && wb_addr!=0.
  - x0 reads 0 regardless of writes.
- Scoreboard:
  - pending[r] set on accept of a legal op with rd!=0.
  - pending[r] cleared when wb_en && wb_addr==r.
  - Same-cycle set and clear of the same r: set wins.
- Hazard:
  - Raised for a legal op when pending[rs1], pending[rs2] (OP only), or pending[rd] is set (rd!=0).
  - Registers x0 never cause hazard.
  - With WB_BYPASS=1, a register being cleared by wb this cycle counts as not pending, and its read returns wb_data.
  - With WB_BYPASS=0, it stalls one more cycle.
- Stall: in_instr must be held by upstream while in_valid && !in_ready. The stage keeps no copy until accept.

Test Plan:
- Reset, then in_instr=0x00500093 (ADDI x1,x0,5) -> next cycle ex_valid=1, funct3=0, funct7=0, op_a=0, op_b=5, rd=1; pending[1]=1.
- After the above, present 0x002081B3 (ADD x3,x1,x2) with no wb -> in_ready=0 indefinitely. Then wb_en=1, wb_addr=1, wb_data=5 (WB_BYPASS=1) -> accepted same cycle, op_a=5.
- 0x402081B3 (SUB) with x1=7, x2=3, no pending -> funct7=0x20, op_a=7, op_b=3. Hold ex_ready=0 for 3 cycles -> outputs stable, in_ready=0.
- 0x4030D293 (SRAI x5,x1,3) -> funct3=5, funct7=0x20, op_b=3. 0xFFF00113 (ADDI x2,x0,-1) -> op_b=0xFFFFFFFF.
- Opcode 0x03 (load) -> ex_illegal=1, scoreboard unchanged. OP with funct7=0x20, funct3=1 -> ex_illegal=1.
- wb_en=1, wb_addr=0, wb_data=0xDEADBEEF, then ADD x3,x0,x0 -> op_a=op_b=0. Assert rst while ex_valid=1 and pending set -> ex_valid=0, all pending cleared next cycle.

Source files
------------

// File: rtl/decode_issue.sv
// Decode/operand-fetch stage feeding the RV32IM ALU: decodes OP/OP-IMM, reads the
// register file and holds a one-entry issue register guarded by a RAW/WAW scoreboard.
module decode_issue #(
  parameter int XLEN      = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [XLEN-1:0] ex_op_a,
  output logic [XLEN-1:0] ex_op_b,
  output logic [4:0]      ex_rd,
  output logic            ex_illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  typedef struct packed {
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd;
    logic            illegal;
  } ex_pkt_t;

  logic [31:0][XLEN-1:0] rf_q, rf_d;
  logic [31:0]           pend_q, pend_d;
  logic                  ex_valid_q, ex_valid_d;
  ex_pkt_t               ex_q, ex_d, dec;

  logic [6:0]      opcode, f7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic            is_op, is_imm, legal, hazard, accept;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [31:0]     wb_clr, pend_eff;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign f3     = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign f7     = in_instr[31:25];
  assign is_op  = (opcode == OPC_OP);
  assign is_imm = (opcode == OPC_IMM);

  always_comb begin
    legal = 1'b0;
    if (is_op) begin
      legal = (f7 == 7'h00) || (f7 == 7'h01) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5));
    end else if (is_imm) begin
      case (f3)
        3'd1:    legal = (f7 == 7'h00);
        3'd5:    legal = (f7 == 7'h00) || (f7 == 7'h20);
        default: legal = 1'b1;
      endcase
    end
  end

  // A writeback landing this cycle both frees its scoreboard bit and supplies the operand.
  assign wb_clr   = wb_en ? (32'd1 << wb_addr) : 32'd0;
  assign pend_eff = WB_BYPASS ? (pend_q & ~wb_clr) : pend_q;
  assign rs1_val  = (rs1 == 5'd0) ? '0 :
                    (WB_BYPASS && wb_en && wb_addr == rs1) ? wb_data : rf_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 :
                    (WB_BYPASS && wb_en && wb_addr == rs2) ? wb_data : rf_q[rs2];

  assign hazard   = legal && ((rs1 != 5'd0 && pend_eff[rs1]) ||
                              (is_op && rs2 != 5'd0 && pend_eff[rs2]) ||
                              (rd != 5'd0 && pend_eff[rd]));
  assign in_ready = (!ex_valid_q || ex_ready) && !hazard && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec         = '0;
    dec.illegal = !legal;
    if (legal) begin
      dec.funct3 = f3;
      dec.rd     = rd;
      dec.op_a   = rs1_val;
      if (is_op) begin
        dec.funct7 = f7;
        dec.op_b   = rs2_val;
      end else begin
        case (f3)
          3'd1: dec.op_b = {{(XLEN-5){1'b0}}, in_instr[24:20]};
          3'd5: begin
            dec.op_b   = {{(XLEN-5){1'b0}}, in_instr[24:20]};
            dec.funct7 = f7;
          end
          default: dec.op_b = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        endcase
      end
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_d       = dec;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
    // Set after clear so a same-cycle reissue of rd keeps it pending.
    pend_d = pend_q & ~wb_clr;
    if (accept && legal && rd != 5'd0) pend_d[rd] = 1'b1;
    rf_d = rf_q;
    if (wb_en && wb_addr != 5'd0) rf_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      pend_q     <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
      pend_q     <= pend_d;
    end
  end

  always_ff @(posedge clk) rf_q <= rf_d;

  assign ex_valid   = ex_valid_q;
  assign ex_funct3  = ex_q.funct3;
  assign ex_funct7  = ex_q.funct7;
  assign ex_op_a    = ex_q.op_a;
  assign ex_op_b    = ex_q.op_b;
  assign ex_rd      = ex_q.rd;
  assign ex_illegal = ex_q.illegal;
endmodule
